// File: rtl/inj_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : inj_arbiter_pkg
//  Description : Shared network configuration for the PE injection path.
//                Provides the node count and the packet type that every
//                local traffic source hands to the injection arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package inj_arbiter_pkg;

    // Network geometry
    localparam int NUM_NODES = 16;
    localparam int NODE_W    = $clog2(NUM_NODES);

    // Packet layout: destination node id followed by payload
    localparam int PAYLOAD_W = 12;

    typedef struct packed {
        logic [NODE_W-1:0]    dest;
        logic [PAYLOAD_W-1:0] payload;
    } packet_t;

    localparam int PKT_W = $bits(packet_t);

endpackage : inj_arbiter_pkg
`default_nettype wire

// File: rtl/inj_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : inj_fifo
//  Description : Single-clock packet FIFO with occupancy count, one per
//                injection source. The head entry is presented
//                combinationally from storage; a word written on an edge is
//                only visible after that edge (no write-to-read bypass).
//  Ports       : clk, reset_n       - clock, async active-low reset
//                i_wr_en/i_wr_data  - push request and packet
//                i_rd_en            - pop the head entry
//                o_rd_data          - current head entry
//                o_ready            - room for one more packet
//                o_count            - registered occupancy
//  Revision    : 1.0 - initial release
// ============================================================================
module inj_fifo
    import inj_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         i_wr_en,
    input  packet_t                      i_wr_data,
    input  logic                         i_rd_en,
    output packet_t                      o_rd_data,
    output logic                         o_ready,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    packet_t            r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    logic               w_full;
    logic               w_wr;
    logic               w_rd;

    // Ready comes from the registered count only, so a full FIFO stays
    // not-ready even in a cycle where it is also being popped.
    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_wr    = i_wr_en && !w_full;
    assign w_rd    = i_rd_en && (r_count != '0);

    assign o_ready   = !w_full;
    assign o_count   = r_count;
    assign o_rd_data = r_mem[r_rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is not reset; discarded entries are unreachable once the
    // pointers and count return to zero.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

endmodule : inj_fifo
`default_nettype wire

// File: rtl/inj_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : inj_arbiter
//  Description : Merges SRC local traffic sources onto one node's PE
//                injection port. Each source has its own FIFO; while the
//                network enables the local port, one non-empty FIFO per
//                cycle is granted round-robin and its head is registered
//                onto the output as a single-cycle valid pulse.
//  Ports       : clk, reset_n              - clock, async active-low reset
//                i_src_data/i_src_val      - per-source packet offer
//                o_src_ready               - per-source FIFO has room
//                i_net_en                  - bit 0 permits injection
//                o_data/o_data_val         - registered packet to network
//                o_src_count               - per-source FIFO occupancy
//  Revision    : 1.0 - initial release
// ============================================================================
module inj_arbiter
    import inj_arbiter_pkg::*;
#(
    parameter int SRC        = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                                       clk,
    input  logic                                       reset_n,
    input  packet_t [0:SRC-1]                          i_src_data,
    input  logic    [0:SRC-1]                          i_src_val,
    output logic    [0:SRC-1]                          o_src_ready,
    input  logic    [3:0]                              i_net_en,
    output packet_t                                    o_data,
    output logic                                       o_data_val,
    output logic    [0:SRC-1][$clog2(FIFO_DEPTH+1)-1:0] o_src_count
);

    localparam int PTR_W = (SRC > 1) ? $clog2(SRC) : 1;

    logic    [0:SRC-1]  w_wr_en;
    logic    [0:SRC-1]  w_pop;
    logic    [0:SRC-1]  w_nonempty;
    packet_t [0:SRC-1]  w_head;

    logic               w_permit;
    logic               w_unused_net_en;
    logic               w_grant_any;
    logic [PTR_W-1:0]   w_grant_idx;
    logic [PTR_W-1:0]   w_cand;
    logic [PTR_W-1:0]   w_rr_next;

    logic [PTR_W-1:0]   r_rr_ptr;
    packet_t            r_data;
    logic               r_data_val;

    // Only bit 0 of the network enable belongs to this local port.
    assign w_permit        = i_net_en[0];
    assign w_unused_net_en = ^i_net_en[3:1];

    for (genvar g = 0; g < SRC; g++) begin : g_src
        assign w_wr_en[g]    = i_src_val[g] && o_src_ready[g];
        assign w_nonempty[g] = (o_src_count[g] != '0);
        assign w_pop[g]      = w_grant_any && (w_grant_idx == PTR_W'(g));

        inj_fifo #(
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk       (clk),
            .reset_n   (reset_n),
            .i_wr_en   (w_wr_en[g]),
            .i_wr_data (i_src_data[g]),
            .i_rd_en   (w_pop[g]),
            .o_rd_data (w_head[g]),
            .o_ready   (o_src_ready[g]),
            .o_count   (o_src_count[g])
        );
    end

    // Round-robin search: start at r_rr_ptr, wrap past SRC-1 to 0, first
    // non-empty FIFO wins. Non-empty is judged on registered counts, so a
    // packet written this edge cannot be granted until the next one.
    always_comb begin
        w_grant_any = 1'b0;
        w_grant_idx = '0;
        w_cand      = '0;
        for (int i = 0; i < SRC; i++) begin
            w_cand = PTR_W'((int'(r_rr_ptr) + i) % SRC);
            if (!w_grant_any && w_permit && w_nonempty[w_cand]) begin
                w_grant_any = 1'b1;
                w_grant_idx = w_cand;
            end
        end
    end

    assign w_rr_next = (w_grant_idx == PTR_W'(SRC-1)) ? '0 : (w_grant_idx + 1'b1);

    // Output register: data holds between grants; valid pulses per packet.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rr_ptr   <= '0;
            r_data     <= '0;
            r_data_val <= 1'b0;
        end else begin
            r_data_val <= w_grant_any;
            if (w_grant_any) begin
                r_data   <= w_head[w_grant_idx];
                r_rr_ptr <= w_rr_next;
            end
        end
    end

    assign o_data     = r_data;
    assign o_data_val = r_data_val;

endmodule : inj_arbiter
`default_nettype wire
